// File: rtl/ewb_burst_adaptor.sv
// Converts whole-cacheline read/write requests from the eviction write buffer
// into a sequence of narrower memory bursts, reassembling read data into a line.
module ewb_burst_adaptor #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               read_i,
   input  logic               write_i,
   input  logic [ADDR_W-1:0]  address_i,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   output logic               resp_o,
   output logic               read_o,
   output logic               write_o,
   output logic [ADDR_W-1:0]  address_o,
   output logic [BURST_W-1:0] burst_o,
   input  logic [BURST_W-1:0] burst_i,
   input  logic               resp_i
);

   localparam int BEATS = LINE_W / BURST_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFF_W = $clog2(LINE_W / 8);
   // Clears the byte-offset-within-line bits so memory always sees a line-aligned address.
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
   localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [LINE_W-1:0]  data_r;

   logic [CNT_W-1:0]   cnt_next_s;
   logic [LINE_W-1:0]  assembled_s;
   logic [BURST_W-1:0] next_burst_s;

   // Beat bookkeeping: line with the current read beat merged in, and the next write burst.
   always_comb begin
      cnt_next_s   = cnt_r + CNT_W'(1'b1);
      assembled_s  = data_r;
      assembled_s[cnt_r*BURST_W +: BURST_W] = burst_i;
      next_burst_s = data_r[cnt_next_s*BURST_W +: BURST_W];
   end

   // Transaction FSM with all memory-side and upstream outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         data_r    <= '0;
         line_o    <= '0;
         resp_o    <= 1'b0;
         read_o    <= 1'b0;
         write_o   <= 1'b0;
         address_o <= '0;
         burst_o   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               resp_o <= 1'b0;
               if (write_i) begin
                  // Write wins when both requests arrive together.
                  state_r   <= WRITE;
                  cnt_r     <= '0;
                  data_r    <= line_i;
                  write_o   <= 1'b1;
                  read_o    <= 1'b0;
                  address_o <= address_i & ALIGN_MASK;
                  burst_o   <= line_i[BURST_W-1:0];
               end else if (read_i) begin
                  state_r   <= READ;
                  cnt_r     <= '0;
                  read_o    <= 1'b1;
                  write_o   <= 1'b0;
                  address_o <= address_i & ALIGN_MASK;
                  burst_o   <= '0;
               end else begin
                  state_r <= IDLE;
               end
            end

            READ: begin
               if (resp_i) begin
                  data_r <= assembled_s;
                  cnt_r  <= cnt_next_s;
                  if (cnt_r == LAST_BEAT) begin
                     state_r   <= DONE;
                     line_o    <= assembled_s;
                     resp_o    <= 1'b1;
                     read_o    <= 1'b0;
                     address_o <= '0;
                  end else begin
                     state_r <= READ;
                  end
               end else begin
                  state_r <= READ;
               end
            end

            WRITE: begin
               if (resp_i) begin
                  cnt_r <= cnt_next_s;
                  if (cnt_r == LAST_BEAT) begin
                     state_r   <= DONE;
                     resp_o    <= 1'b1;
                     write_o   <= 1'b0;
                     address_o <= '0;
                     burst_o   <= '0;
                  end else begin
                     state_r <= WRITE;
                     burst_o <= next_burst_s;
                  end
               end else begin
                  state_r <= WRITE;
               end
            end

            DONE: begin
               state_r <= IDLE;
               resp_o  <= 1'b0;
            end

            default: begin
               state_r   <= IDLE;
               cnt_r     <= '0;
               resp_o    <= 1'b0;
               read_o    <= 1'b0;
               write_o   <= 1'b0;
               address_o <= '0;
               burst_o   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/ewb_burst_adaptor.md
EWB_BURST_ADAPTOR -- requirements
Module: ewb_burst_adaptor

Interface
REQ-001: Parameter LINE_W, 256, cacheline width in bits.
REQ-002: Parameter BURST_W, 64, memory burst width in bits; LINE_W/BURST_W = 4 bursts per line.
REQ-003: Parameter ADDR_W, 32, address width.
REQ-004: clk  in  1  sole clock; all state updates on rising edge.
REQ-005: rst_n  in  1  reset, asynchronous, active-low.
REQ-006: read_i  in  1  line read request from eviction write buffer, held until resp_o.
REQ-007: write_i  in  1  line write request from eviction write buffer, held until resp_o.
REQ-008: address_i  in  ADDR_W  line address of request.
REQ-009: line_i  in  LINE_W  write line data.
REQ-010: line_o  out  LINE_W  assembled read line, valid when resp_o=1.
REQ-011: resp_o  out  1  one-cycle completion pulse to eviction write buffer.
REQ-012: read_o  out  1  burst read request to physical memory.
REQ-013: write_o  out  1  burst write request to physical memory.
REQ-014: address_o  out  ADDR_W  line-aligned memory address.
REQ-015: burst_o  out  BURST_W  current write burst.
REQ-016: burst_i  in  BURST_W  read burst, valid when resp_i=1.
REQ-017: resp_i  in  1  memory beat strobe; one beat transferred per cycle resp_i=1.

Function
REQ-018: FSM states SHALL be IDLE, READ, WRITE, DONE, plus a 2-bit beat counter cnt.
REQ-019: IDLE: on write_i=1, capture address_i and line_i, cnt<=0, go WRITE; else on read_i=1, capture address_i, cnt<=0, go READ; else stay.
REQ-020: Simultaneous read_i and write_i in IDLE -> write SHALL take priority.
REQ-021: address_o SHALL equal captured address with bits [4:0] forced to 0, driven in READ and WRITE; 0 otherwise.
REQ-022: read_o SHALL be 1 exactly in READ; write_o exactly in WRITE; first assertion one cycle after request sampled.
REQ-023: READ: each cycle resp_i=1 SHALL store burst_i into line segment [cnt*64 +: 64] and increment cnt; non-beat cycles hold state.
REQ-024: WRITE: burst_o SHALL equal captured line segment [cnt*64 +: 64]; each resp_i=1 increments cnt.
REQ-025: Beat with cnt=3 SHALL transition to DONE; cnt wraps to 0.
REQ-026: DONE: resp_o=1 for exactly one cycle, line_o holds assembled line, then go IDLE unconditionally.
REQ-027: line_o SHALL hold last assembled line after DONE until next read completes.
REQ-028: resp_i in IDLE or DONE SHALL be ignored (no capture, no count).
REQ-029: Request changes while in READ/WRITE/DONE SHALL be ignored; captured address/line used.
REQ-030: Minimum latency request-to-resp_o = 6 cycles with back-to-back beats (1 capture + 4 beats + DONE).
REQ-031: Request still asserted in IDLE cycle after DONE SHALL start a new transaction (upstream deasserts on resp_o).
REQ-032: burst_o SHALL be 0 outside WRITE.

Reset
REQ-033: rst_n=0 SHALL asynchronously force IDLE, cnt=0, captured address/line=0, line_o=0, resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0.
REQ-034: Reset mid-transaction SHALL abort it with no resp_o; first cycle after release is IDLE.

Verification
REQ-035: Read 0x0000_1234, memory returns beats 0x11..,0x22..,0x33..,0x44.. on 4 consecutive resp_i -> address_o=0x0000_1220, read_o 4 cycles, resp_o once, line_o = {0x44..,0x33..,0x22..,0x11..}.
REQ-036: Write 0x8000_0040, line_i={D3,D2,D1,D0} -> write_o, address_o=0x8000_0040, burst_o D0,D1,D2,D3 on successive beats, resp_o once after 4th beat.
REQ-037: Read with resp_i gaps (beat, 2 idle, beat, 1 idle, 2 beats) -> all 4 beats captured in order, resp_o after last beat only.
REQ-038: read_i=write_i=1 in IDLE -> WRITE entered, read_o never asserted.
REQ-039: rst_n pulled low after 2 read beats -> all outputs 0 immediately, no resp_o; new read afterwards completes normally.
REQ-040: Back-to-back read then write (upstream reasserts write_i cycle after resp_o) -> second transaction starts in following IDLE cycle; stray resp_i in IDLE ignored.
